// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: computes a - b - bin for one bit position
// and produces the borrow passed to the next more-significant cell.
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic diff_o,
   output logic bout_o
);

   logic a_xor_b;

   assign a_xor_b = a_i ^ b_i;
   assign diff_o  = a_xor_b ^ bin_i;
   // A borrow is needed when a=0,b=1, or when a==b and a borrow arrives from below
   assign bout_o  = (~a_i & b_i) | (~a_xor_b & bin_i);

endmodule

// File: rtl/subtractor_n.sv
// Unsigned nb_bit-wide subtractor built as a ripple chain of full_subtractor
// cells. Computes (a_i - b_i) mod 2^nb_bit; borrow_o flags a_i < b_i.
// Both results are registered once, giving one cycle of latency at full throughput.
module subtractor_n #(
   parameter int unsigned nb_bit = 24
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [nb_bit-1:0] a_i,
   input  logic [nb_bit-1:0] b_i,
   output logic              borrow_o,
   output logic [nb_bit-1:0] diff_o
);

   // borrow_w[k] is the borrow into cell k; borrow_w[nb_bit] leaves the MSB cell
   logic [nb_bit:0]   borrow_w;
   logic [nb_bit-1:0] diff_d;
   logic [nb_bit-1:0] diff_q;
   logic              borrow_d;
   logic              borrow_q;

   // No external borrow-in: the chain always starts from zero
   assign borrow_w[0] = 1'b0;

   for (genvar k = 0; k < int'(nb_bit); k++) begin : g_cell
      full_subtractor u_cell (
         .a_i    (a_i[k]),
         .b_i    (b_i[k]),
         .bin_i  (borrow_w[k]),
         .diff_o (diff_d[k]),
         .bout_o (borrow_w[k+1])
      );
   end

   assign borrow_d = borrow_w[nb_bit];

   // Output register: clears asynchronously, captures a fresh result every edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;

endmodule

// File: tb/tb_subtractor_n.sv
// Scoreboard bench for subtractor_n: three instances (24, 8 and 1 bit) run
// side by side. The 24-bit one gets directed corner pairs then random pairs,
// the 8-bit and 1-bit ones are swept exhaustively over all operand pairs.
module tb_subtractor_n;

   typedef struct {
      logic [63:0] d;
      logic        b;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [23:0] a24, b24, d24;
   logic [7:0]  a8, b8, d8;
   logic [0:0]  a1, b1, d1;
   logic        bo24, bo8, bo1;

   exp_t q24[$];
   exp_t q8[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;

   localparam int N_ITER   = 65536;
   localparam int RST_ITER = 20000;

   subtractor_n #(.nb_bit(24)) u_dut24 (
      .clk_i(clk), .rst_ni(rst_n), .a_i(a24), .b_i(b24), .borrow_o(bo24), .diff_o(d24));
   subtractor_n #(.nb_bit(8)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .a_i(a8), .b_i(b8), .borrow_o(bo8), .diff_o(d8));
   subtractor_n #(.nb_bit(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .a_i(a1), .b_i(b1), .borrow_o(bo1), .diff_o(d1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain modular subtraction and unsigned compare
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int w);
      exp_t e;
      logic [63:0] mask;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      e.d = (a - b) & mask;
      e.b = (a < b);
      return e;
   endfunction

   task automatic push_all();
      q24.push_back(model({40'd0, a24}, {40'd0, b24}, 24));
      q8.push_back(model({56'd0, a8}, {56'd0, b8}, 8));
      q1.push_back(model({63'd0, a1}, {63'd0, b1}, 1));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_d24"}, {40'd0, d24}, 64'd0);
      chk({tag, "_b24"}, {63'd0, bo24}, 64'd0);
      chk({tag, "_d8"},  {56'd0, d8},  64'd0);
      chk({tag, "_b8"},  {63'd0, bo8},  64'd0);
      chk({tag, "_d1"},  {63'd0, d1},  64'd0);
      chk({tag, "_b1"},  {63'd0, bo1},  64'd0);
   endtask

   // Monitor: just after each rising edge, outputs either must be cleared
   // (reset low) or must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            chk_zero("rst");
         end else begin
            if (q24.size() > 0) begin
               e = q24.pop_front();
               chk("diff24", {40'd0, d24}, e.d);
               chk("borrow24", {63'd0, bo24}, {63'd0, e.b});
            end
            if (q8.size() > 0) begin
               e = q8.pop_front();
               chk("diff8", {56'd0, d8}, e.d);
               chk("borrow8", {63'd0, bo8}, {63'd0, e.b});
            end
            if (q1.size() > 0) begin
               e = q1.pop_front();
               chk("diff1", {63'd0, d1}, e.d);
               chk("borrow1", {63'd0, bo1}, {63'd0, e.b});
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [23:0] dir_a [6];
      logic [23:0] dir_b [6];
      logic [15:0] idx;
      dir_a = '{24'hABCDEF, 24'h000000, 24'h000001, 24'h800000, 24'hFFFFFF, 24'hFFFFFF};
      dir_b = '{24'hABCDEF, 24'h000001, 24'hFFFFFF, 24'h000001, 24'h000000, 24'hFFFFFF};

      rst_n = 1'b0;
      a24 = 24'h00000A; b24 = 24'h000003;
      a8 = 8'h05; b8 = 8'h09;
      a1 = 1'b0; b1 = 1'b1;
      #1;
      chk_zero("rst_init");
      repeat (3) @(negedge clk);

      for (int i = 0; i < N_ITER; i++) begin
         if (i == RST_ITER) begin
            // Mid-stream asynchronous reset: outputs must clear without a clock edge
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk_zero("rst_async");
            repeat (2) @(negedge clk);
         end
         @(negedge clk);
         rst_n = 1'b1;
         idx = i[15:0];
         if (i == 0) begin
            a24 = 24'h00000A; b24 = 24'h000003;
         end else if (i <= 6) begin
            a24 = dir_a[i-1]; b24 = dir_b[i-1];
         end else begin
            a24 = 24'($urandom());
            b24 = ($urandom_range(0, 7) == 0) ? a24 : 24'($urandom());
         end
         a8 = idx[15:8]; b8 = idx[7:0];
         a1 = idx[1];    b1 = idx[0];
         push_all();
      end

      repeat (3) @(negedge clk);
      chk("drain24", 64'(q24.size()), 64'd0);
      chk("drain8",  64'(q8.size()),  64'd0);
      chk("drain1",  64'(q1.size()),  64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
